// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline types for the operand forwarding / hazard logic.
// No logic: types and constants only.
// No flow control.
package forward_hazard_unit_pkg;

  // Architectural register address width; register 0 reads as zero.
  localparam int REG_AW = 5;

  // Stage indices counted from issue.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // One in-flight destination tag.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } fwd_tag_t;

endpackage

// File: rtl/forward_hazard_unit_operand_sel.sv
// Picks the youngest in-flight producer of one source operand.
// Combinational, zero cycles.
// Flags a hazard when the winning producer is a load whose data is not ready yet.
module fwd_operand_sel
  import forward_hazard_unit_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NSTAGE   = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                   use_op,
  input  logic [REG_AW-1:0]      addr,
  input  logic [XLEN-1:0]        id_val,
  input  fwd_tag_t [NSTAGE-1:0]  tags,
  input  logic [NSTAGE*XLEN-1:0] stage_res,
  output logic [XLEN-1:0]        fwd_val,
  output logic                   hazard
);

  logic found;

  // Scan from the youngest stage; the first matching valid tag wins.
  always_comb begin
    fwd_val = id_val;
    hazard  = 1'b0;
    found   = 1'b0;
    if (use_op && (addr != '0)) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found && tags[k].valid && (tags[k].rd == addr)) begin
          found = 1'b1;
          if (tags[k].is_load && (k < LOAD_LAT)) begin
            hazard = 1'b1;
          end else begin
            fwd_val = stage_res[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks in-flight destination tags and forwards operands from later stages into EX.
// Forwarding is combinational; tags advance one stage per cycle.
// Raises stall (hold IF/ID, bubble into EX) while a needed load result is not yet valid.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NSTAGE   = 3,
  parameter int LOAD_LAT = STG_MEM,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic                   id_rd_we,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_load,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic                   id_use_st,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic [REG_AW-1:0]      id_st_reg,
  input  logic [XLEN-1:0]        id_op1,
  input  logic [XLEN-1:0]        id_op2,
  input  logic [XLEN-1:0]        id_st_val,
  input  logic [NSTAGE*XLEN-1:0] stage_res,
  output logic [XLEN-1:0]        op1_fwd,
  output logic [XLEN-1:0]        op2_fwd,
  output logic [XLEN-1:0]        st_fwd,
  output logic                   stall,
  output logic [CNT_W-1:0]       stall_count
);

  // A load result must become visible inside the tracked window.
  if (NSTAGE < 1 || LOAD_LAT < 0 || LOAD_LAT >= NSTAGE) begin : g_bad_load_lat
    $fatal(1, "forward_hazard_unit: LOAD_LAT must be in [0, NSTAGE-1]");
  end

  fwd_tag_t [NSTAGE-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  logic [XLEN-1:0] sel1_val, sel2_val, selst_val;
  logic            haz1, haz2, hazst;

  fwd_operand_sel #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) u_sel_rs1 (
    .use_op    (id_use_rs1),
    .addr      (id_rs1),
    .id_val    (id_op1),
    .tags      (tag_q),
    .stage_res (stage_res),
    .fwd_val   (sel1_val),
    .hazard    (haz1)
  );

  fwd_operand_sel #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) u_sel_rs2 (
    .use_op    (id_use_rs2),
    .addr      (id_rs2),
    .id_val    (id_op2),
    .tags      (tag_q),
    .stage_res (stage_res),
    .fwd_val   (sel2_val),
    .hazard    (haz2)
  );

  fwd_operand_sel #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) u_sel_st (
    .use_op    (id_use_st),
    .addr      (id_st_reg),
    .id_val    (id_st_val),
    .tags      (tag_q),
    .stage_res (stage_res),
    .fwd_val   (selst_val),
    .hazard    (hazst)
  );

  // While reset is held the tags may be stale, so pass ID values straight through.
  always_comb begin
    op1_fwd = rst ? id_op1    : sel1_val;
    op2_fwd = rst ? id_op2    : sel2_val;
    st_fwd  = rst ? id_st_val : selst_val;
    stall   = !rst && id_valid && !flush && (haz1 || haz2 || hazst);
  end

  // Next tag vector: insert the issuing instruction (or a bubble) and age the rest.
  always_comb begin
    tag_d = tag_q;
    tag_d[STG_EX].valid   = id_valid && id_rd_we && (id_rd != '0) && !stall && !flush;
    tag_d[STG_EX].rd      = id_rd;
    tag_d[STG_EX].is_load = id_load;
    for (int k = 1; k < NSTAGE; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q         <= '0;
      stall_count_q <= '0;
    end else begin
      tag_q         <= tag_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;
  import forward_hazard_unit_pkg::*;

  localparam int XLEN     = 64;
  localparam int NSTAGE   = 3;
  localparam int LOAD_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, flush, id_valid, id_rd_we, id_load;
  logic                   id_use_rs1, id_use_rs2, id_use_st;
  logic [REG_AW-1:0]      id_rd, id_rs1, id_rs2, id_st_reg;
  logic [XLEN-1:0]        id_op1, id_op2, id_st_val;
  logic [NSTAGE*XLEN-1:0] stage_res;
  logic [XLEN-1:0]        op1_fwd, op2_fwd, st_fwd, op1_fwd4, op2_fwd4, st_fwd4;
  logic                   stall, stall4;
  logic [31:0]            stall_count;
  logic [3:0]             stall_count4;

  forward_hazard_unit #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_rd_we(id_rd_we),
    .id_rd(id_rd), .id_load(id_load), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_use_st(id_use_st), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_st_reg(id_st_reg),
    .id_op1(id_op1), .id_op2(id_op2), .id_st_val(id_st_val), .stage_res(stage_res),
    .op1_fwd(op1_fwd), .op2_fwd(op2_fwd), .st_fwd(st_fwd), .stall(stall),
    .stall_count(stall_count)
  );

  // Narrow-counter build used to observe saturation.
  forward_hazard_unit #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_rd_we(id_rd_we),
    .id_rd(id_rd), .id_load(id_load), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_use_st(id_use_st), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_st_reg(id_st_reg),
    .id_op1(id_op1), .id_op2(id_op2), .id_st_val(id_st_val), .stage_res(stage_res),
    .op1_fwd(op1_fwd4), .op2_fwd(op2_fwd4), .st_fwd(st_fwd4), .stall(stall4),
    .stall_count(stall_count4)
  );

  // Reference model: history of issued instructions, index = cycles since issue.
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } rec_t;

  rec_t    hist[$];
  longint  cnt_m;
  bit      cnt_known;
  int      n_tests, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected forwarded value and hazard for one operand, from the issue history.
  task automatic model_op(input bit use_op, input int addr, input logic [XLEN-1:0] idv,
                          output logic [XLEN-1:0] val, output bit haz);
    val = idv;
    haz = 1'b0;
    if (rst || !use_op || addr == 0) return;
    for (int age = 0; age < hist.size(); age++) begin
      if (hist[age].v && hist[age].rd == addr) begin
        if (hist[age].ld && age < LOAD_LAT) haz = 1'b1;
        else val = stage_res[age*XLEN +: XLEN];
        return;
      end
    end
  endtask

  task automatic clear_hist();
    rec_t b;
    b.v = 1'b0; b.rd = 0; b.ld = 1'b0;
    hist.delete();
    for (int i = 0; i < NSTAGE; i++) hist.push_back(b);
  endtask

  // Check the current cycle against the model, then clock and advance the model.
  task automatic step();
    logic [XLEN-1:0] e1, e2, es;
    bit h1, h2, hs, st_e;
    rec_t r;
    #1;
    model_op(id_use_rs1, int'(id_rs1), id_op1, e1, h1);
    model_op(id_use_rs2, int'(id_rs2), id_op2, e2, h2);
    model_op(id_use_st, int'(id_st_reg), id_st_val, es, hs);
    st_e = !rst && id_valid && !flush && (h1 || h2 || hs);
    if (!h1) chk("op1_fwd", op1_fwd, e1);
    if (!h2) chk("op2_fwd", op2_fwd, e2);
    if (!hs) chk("st_fwd", st_fwd, es);
    chk("stall", {63'd0, stall}, {63'd0, st_e});
    chk("stall_w4", {63'd0, stall4}, {63'd0, st_e});
    if (cnt_known) begin
      chk("stall_count", {32'd0, stall_count}, 64'(cnt_m));
      chk("stall_count_sat4", {60'd0, stall_count4}, (cnt_m > 15) ? 64'd15 : 64'(cnt_m));
    end
    @(posedge clk);
    if (rst) begin
      clear_hist();
      cnt_m = 0;
      cnt_known = 1'b1;
    end else begin
      r.v  = id_valid && id_rd_we && (id_rd != 0) && !st_e && !flush;
      r.rd = int'(id_rd);
      r.ld = id_load;
      hist.push_front(r);
      void'(hist.pop_back());
      if (st_e && cnt_m < 64'hFFFF_FFFF) cnt_m++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0; id_valid = 0; id_rd_we = 0; id_rd = 0; id_load = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_use_st = 0;
    id_rs1 = 0; id_rs2 = 0; id_st_reg = 0;
    id_op1 = {$urandom, $urandom}; id_op2 = {$urandom, $urandom};
    id_st_val = {$urandom, $urandom};
    for (int k = 0; k < NSTAGE; k++) stage_res[k*XLEN +: XLEN] = {$urandom, $urandom};
  endtask

  task automatic issue(input int rd, input bit ld);
    idle();
    id_valid = 1; id_rd_we = 1; id_rd = REG_AW'(rd); id_load = ld;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cnt_m = 0; cnt_known = 0;
    clear_hist();
    idle();
    rst = 1;
    @(negedge clk);
    step();
    idle(); rst = 1; step();

    // ALU back-to-back
    issue(5, 0); step();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    stage_res[STG_EX*XLEN +: XLEN] = 64'h11; step();

    // Priority: youngest producer wins; unused rs2 passes through
    issue(7, 0); step();
    issue(7, 0); step();
    idle(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 7;
    stage_res[STG_EX*XLEN +: XLEN] = 64'hAA; stage_res[STG_MEM*XLEN +: XLEN] = 64'hBB;
    step();
    id_use_rs2 = 0; step();

    // Load-use: one stall, then forward from MEM
    issue(3, 1); step();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 3; step();
    stage_res[STG_MEM*XLEN +: XLEN] = 64'hDEAD; step();

    // x0 never forwards
    issue(0, 0); step();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 0; step();

    // Flush beats a load-use hazard
    issue(3, 1); step();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 3; flush = 1; step();

    // Store data forwarding from WB, then aged out
    issue(9, 0); step();
    idle(); step();
    idle(); step();
    idle(); id_valid = 1; id_use_st = 1; id_st_reg = 9;
    stage_res[STG_WB*XLEN +: XLEN] = 64'h1234; step();
    idle(); id_valid = 1; id_use_st = 1; id_st_reg = 9; step();

    // Reset in the middle of a stall
    issue(4, 1); step();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 4; step();
    rst = 1; step();
    rst = 0; step();

    // Repeated load-use stalls to drive the narrow counter into saturation
    for (int i = 0; i < 20; i++) begin
      issue(6, 1); step();
      idle(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 6; step();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      id_valid   = ($urandom_range(0, 9) != 0);
      id_rd_we   = ($urandom_range(0, 3) != 0);
      id_load    = ($urandom_range(0, 2) == 0);
      id_rd      = REG_AW'($urandom_range(0, 7));
      id_use_rs1 = $urandom_range(0, 1);
      id_use_rs2 = $urandom_range(0, 1);
      id_use_st  = ($urandom_range(0, 3) == 0);
      id_rs1     = REG_AW'($urandom_range(0, 7));
      id_rs2     = REG_AW'($urandom_range(0, 7));
      id_st_reg  = REG_AW'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
